// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding, default geometry/widths and width helpers for the kernel scheduler
package cnn_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_OUT} state_e;

    localparam int KX_DEF     = 5;
    localparam int KY_DEF     = 5;
    localparam int CI_DEF     = 2;
    localparam int CO_DEF     = 4;
    localparam int I_F_BW_DEF = 8;
    localparam int W_BW_DEF   = 8;
    localparam int B_BW_DEF   = 8;
    localparam int AK_BW_DEF  = 21;

    // Channel-sum width: kernel result plus growth for CI additions plus one bit of headroom for the bias
    function automatic int acc_bw(input int ak_bw, input int ci);
        return ak_bw + $clog2(ci) + 1;
    endfunction

    // Index width that never collapses to zero bits
    function automatic int idx_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_sched_ch_acc.sv
// cnn_sched_ch_acc: sums CI kernel results, adds bias, optional ReLU (CNN_SCHED_RELU_EN), registers the channel result
module cnn_sched_ch_acc
    import cnn_pkg::*;
#(
    parameter int CI     = CI_DEF,
    parameter int AK_BW  = AK_BW_DEF,
    parameter int B_BW   = B_BW_DEF,
    parameter int ACC_BW = acc_bw(AK_BW_DEF, CI_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              k_valid_i,
    input  logic [AK_BW-1:0]  k_acc_i,
    input  logic [B_BW-1:0]   bias_i,
    output logic              done_o,
    output logic [ACC_BW-1:0] data_o
);

    localparam int CIW = idx_bw(CI);

    logic [ACC_BW-1:0] acc_q, acc_d, sum, res, data_q;
    logic [CIW-1:0]    rcnt_q;

    assign done_o = k_valid_i && (rcnt_q == CIW'(CI - 1));
    assign data_o = data_q;

    // Running sum with the incoming result, then bias and optional clamp for the final result
    always_comb begin
        acc_d = acc_q + {{(ACC_BW-AK_BW){k_acc_i[AK_BW-1]}}, k_acc_i};
        sum   = acc_d + {{(ACC_BW-B_BW){bias_i[B_BW-1]}}, bias_i};
`ifdef CNN_SCHED_RELU_EN
        res   = sum[ACC_BW-1] ? '0 : sum;
`else
        res   = sum;
`endif
    end

    // Results are counted, not timed: the CI-th one closes the channel and clears the sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            rcnt_q <= '0;
            data_q <= '0;
        end else if (k_valid_i) begin
            acc_q  <= done_o ? '0 : acc_d;
            rcnt_q <= done_o ? '0 : rcnt_q + 1'b1;
            if (done_o) data_q <= res;
        end
    end

endmodule

// File: rtl/cnn_kernel_sched.sv
// cnn_kernel_sched: sequences a shared KXxKY MAC kernel over CI input channels for each of CO outputs; ReLU via CNN_SCHED_RELU_EN
module cnn_kernel_sched
    import cnn_pkg::*;
#(
    parameter int KX     = KX_DEF,
    parameter int KY     = KY_DEF,
    parameter int CI     = CI_DEF,
    parameter int CO     = CO_DEF,
    parameter int I_F_BW = I_F_BW_DEF,
    parameter int W_BW   = W_BW_DEF,
    parameter int B_BW   = B_BW_DEF,
    parameter int AK_BW  = AK_BW_DEF,
    parameter int ACC_BW = acc_bw(AK_BW, CI),
    parameter int W_AW   = idx_bw(CI * CO)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [CI*KX*KY*I_F_BW-1:0] i_in_fmap,
    output logic [W_AW-1:0]            o_w_addr,
    input  logic [KX*KY*W_BW-1:0]      i_w_data,
    input  logic [CO*B_BW-1:0]         i_bias,
    output logic                       o_k_valid,
    output logic [KX*KY*I_F_BW-1:0]    o_k_fmap,
    output logic [KX*KY*W_BW-1:0]      o_k_weight,
    input  logic                       i_k_valid,
    input  logic [AK_BW-1:0]           i_k_acc,
    output logic                       o_ot_valid,
    input  logic                       i_ot_ready,
    output logic [ACC_BW-1:0]          o_ot_data,
    output logic [idx_bw(CO)-1:0]      o_ot_ch,
    output logic                       o_ot_last,
    output logic                       o_busy
);

    localparam int SL  = KX * KY * I_F_BW;
    localparam int CIW = idx_bw(CI);
    localparam int COW = idx_bw(CO);

    state_e              state_q, state_d;
    logic [CI*SL-1:0]    win_q;
    logic [CIW-1:0]      ci_q, ci_d1_q;
    logic [COW-1:0]      co_q;
    logic                issue_d1_q;
    logic                ci_last, co_last, acc_en, done;

    assign ci_last    = ci_q == CIW'(CI - 1);
    assign co_last    = co_q == COW'(CO - 1);
    assign acc_en     = i_k_valid && (state_q == ST_ISSUE || state_q == ST_DRAIN);
    assign o_w_addr   = W_AW'(co_q * CI + ci_q);
    assign o_k_valid  = issue_d1_q;
    assign o_k_fmap   = win_q[ci_d1_q*SL +: SL];
    assign o_k_weight = i_w_data;
    assign o_ot_ch    = co_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: issue CI ops, wait for CI results, hold output until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_in_valid) state_d = ST_ISSUE;
            ST_ISSUE: if (ci_last)    state_d = ST_DRAIN;
            ST_DRAIN: if (done)       state_d = ST_OUT;
            ST_OUT:   if (i_ot_ready) state_d = co_last ? ST_IDLE : ST_ISSUE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        o_in_ready = state_q == ST_IDLE;
        o_busy     = state_q != ST_IDLE;
        o_ot_valid = state_q == ST_OUT;
        o_ot_last  = o_ot_valid && co_last;
    end

    // Window capture and channel counters; ci rewinds on leaving ISSUE so the address stays put elsewhere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
            ci_q  <= '0;
            co_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && i_in_valid) begin
                win_q <= i_in_fmap;
                co_q  <= '0;
            end
            if (state_q == ST_ISSUE) ci_q <= ci_last ? '0 : ci_q + 1'b1;
            if (state_q == ST_OUT && i_ot_ready) co_q <= co_last ? '0 : co_q + 1'b1;
        end
    end

    // One-cycle stage aligning the fmap slice with the synchronous ROM read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_d1_q <= 1'b0;
            ci_d1_q    <= '0;
        end else begin
            issue_d1_q <= state_q == ST_ISSUE;
            ci_d1_q    <= ci_q;
        end
    end

    cnn_sched_ch_acc #(
        .CI     (CI),
        .AK_BW  (AK_BW),
        .B_BW   (B_BW),
        .ACC_BW (ACC_BW)
    ) u_acc (
        .clk       (clk),
        .reset     (reset),
        .k_valid_i (acc_en),
        .k_acc_i   (i_k_acc),
        .bias_i    (i_bias[co_q*B_BW +: B_BW]),
        .done_o    (done),
        .data_o    (o_ot_data)
    );

endmodule

// File: tb/tb_cnn_kernel_sched.sv
// tb_cnn_kernel_sched: directed table-driven bench with ROM and 2-cycle kernel models
module tb_cnn_kernel_sched;

    localparam int CI = 2, CO = 2, N = 25;
    localparam int ACC_BW = 23;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_in_valid;
    logic               o_in_ready;
    logic [CI*N*8-1:0]  i_in_fmap;
    logic [1:0]         o_w_addr;
    logic [N*8-1:0]     i_w_data;
    logic [CO*8-1:0]    i_bias;
    logic               o_k_valid;
    logic [N*8-1:0]     o_k_fmap;
    logic [N*8-1:0]     o_k_weight;
    logic               i_k_valid;
    logic [20:0]        i_k_acc;
    logic               o_ot_valid;
    logic               i_ot_ready;
    logic [ACC_BW-1:0]  o_ot_data;
    logic [0:0]         o_ot_ch;
    logic               o_ot_last;
    logic               o_busy;

    int tests = 0, fails = 0, hs_cnt = 0;
    logic [7:0] rom_w [4];
    logic kv1, kv2, spur;
    int   ka1, ka2;

    always #5 clk = ~clk;

    cnn_kernel_sched #(.CI(CI), .CO(CO)) dut (
        .clk(clk), .reset(reset), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_fmap(i_in_fmap), .o_w_addr(o_w_addr), .i_w_data(i_w_data), .i_bias(i_bias),
        .o_k_valid(o_k_valid), .o_k_fmap(o_k_fmap), .o_k_weight(o_k_weight),
        .i_k_valid(i_k_valid), .i_k_acc(i_k_acc), .o_ot_valid(o_ot_valid),
        .i_ot_ready(i_ot_ready), .o_ot_data(o_ot_data), .o_ot_ch(o_ot_ch),
        .o_ot_last(o_ot_last), .o_busy(o_busy)
    );

    function automatic int dot(input logic [N*8-1:0] f, input logic [N*8-1:0] w);
        int s = 0;
        for (int i = 0; i < N; i++) s += $signed(f[i*8 +: 8]) * $signed(w[i*8 +: 8]);
        return s;
    endfunction

    function automatic int expv(input int x);
`ifdef CNN_SCHED_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    always @(posedge clk) i_w_data <= {N{rom_w[o_w_addr]}};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            kv1 <= 1'b0;
            kv2 <= 1'b0;
            ka1 <= 0;
            ka2 <= 0;
        end else begin
            kv1 <= o_k_valid;
            ka1 <= dot(o_k_fmap, o_k_weight);
            kv2 <= kv1;
            ka2 <= ka1;
        end
    end

    assign i_k_valid = kv2 | spur;
    assign i_k_acc   = spur ? 21'd1000 : 21'(ka2);

    always @(posedge clk) if (o_ot_valid && i_ot_ready) hs_cnt++;

    typedef struct {
        int f0, f1, w0, w1, w2, w3, b0, b1, e0, e1;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        logic [7:0] a, b;
        a = 8'(v.f0);
        b = 8'(v.f1);
        i_in_fmap = {{N{b}}, {N{a}}};
        rom_w[0] = 8'(v.w0);
        rom_w[1] = 8'(v.w1);
        rom_w[2] = 8'(v.w2);
        rom_w[3] = 8'(v.w3);
        i_bias = {8'(v.b1), 8'(v.b0)};
    endtask

    // Called at a negedge; returns at the negedge after the last output handshake
    task automatic run_window(input vec_t v, input int bp);
        int n = 0;
        int addr;
        load(v);
        while (!o_in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready", int'(o_in_ready), 1);
        i_in_valid = 1'b1;
        i_ot_ready = (bp == 0);
        @(posedge clk);
        @(negedge clk);
        i_in_valid = 1'b0;
        n = 1;
        for (int c = 0; c < CO; c++) begin
            while (!o_ot_valid && n < 60) begin @(negedge clk); n++; end
            chk($sformatf("latency ch%0d", c), n, 6);
            if (c == 0 && bp > 0) begin
                addr = int'(o_w_addr);
                for (int k = 0; k < bp; k++) begin
                    spur = (k < 2);
                    @(negedge clk);
                    chk("bp held", int'({o_ot_valid, o_k_valid, o_in_ready, o_ot_ch}), 4'b1000);
                    chk("bp data", $signed(o_ot_data), expv(v.e0));
                    chk("bp addr", int'(o_w_addr), addr);
                end
                spur = 1'b0;
                i_ot_ready = 1'b1;
            end
            chk($sformatf("data ch%0d", c), $signed(o_ot_data), expv(c == 0 ? v.e0 : v.e1));
            chk($sformatf("ch ch%0d", c), int'(o_ot_ch), c);
            chk($sformatf("last ch%0d", c), int'(o_ot_last), int'(c == CO - 1));
            @(posedge clk);
            @(negedge clk);
            n = 1;
        end
        chk("idle after window", int'({o_busy, o_in_ready}), 1);
    endtask

    initial begin
        int hs0;
        vecs[0] = '{1, 1, 1, 1, 1, 1, 3, -5, 53, 45};
        vecs[1] = '{1, 1, -1, -1, -1, -1, 0, 0, -50, -50};
        vecs[2] = '{-128, -128, -128, -128, -128, -128, 127, 127, 819327, 819327};
        vecs[3] = '{2, 2, -3, -3, -3, -3, 10, -20, -290, -320};
        vecs[4] = '{3, -2, 2, 1, 1, -1, -1, 7, 99, 132};
        reset = 1'b1;
        i_in_valid = 1'b0;
        i_ot_ready = 1'b1;
        spur = 1'b0;
        load(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        chk("reset state", int'({o_in_ready, o_busy, o_k_valid, o_ot_valid, o_ot_ch, o_ot_last}), 6'b100000);
        chk("reset data", int'(o_ot_data), 0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_window(vecs[i], 0);
        run_window(vecs[0], 5);
        load(vecs[4]);
        i_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_in_valid = 1'b0;
        chk("issue before reset", int'(o_busy), 1);
        reset = 1'b1;
        #1;
        chk("reset mid state", int'({o_in_ready, o_busy, o_k_valid, o_ot_valid, o_ot_ch, o_ot_last}), 6'b100000);
        chk("reset mid data", int'(o_ot_data), 0);
        @(negedge clk);
        reset = 1'b0;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        hs0 = hs_cnt;
        run_window(vecs[0], 0);
        run_window(vecs[4], 0);
        run_window(vecs[3], 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_ot_valid) chk("spurious valid", 1, 0);
        end
        chk("outputs per 3 windows", hs_cnt - hs0, 3 * CO);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
